// File: rtl/instr_fetch_reg_if.sv
// rtl/instr_fetch_reg_if.sv - fetch stage bus: control, instruction memory and decode handshake
interface instr_fetch_reg_if;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] pc_out;
   logic [31:0] inst;
   logic [5:0]  opcode;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [5:0]  funct;
   logic [15:0] imm_16;
   logic [25:0] j_target;

   modport master (
      input  stall, redirect, redirect_pc, mem_ready, mem_rdata, inst_ready,
      output mem_req, mem_addr, inst_valid, pc_out, inst,
             opcode, rs, rt, rd, shamt, funct, imm_16, j_target
   );

   modport slave (
      output stall, redirect, redirect_pc, mem_ready, mem_rdata, inst_ready,
      input  mem_req, mem_addr, inst_valid, pc_out, inst,
             opcode, rs, rt, rd, shamt, funct, imm_16, j_target
   );
endinterface

// File: rtl/instr_fetch_reg.sv
// rtl/instr_fetch_reg.sv - instruction fetch FSM, PC and instruction register with MIPS field split
module instr_fetch_reg #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic                 clk,
   input logic                 rst,
   instr_fetch_reg_if.master   bus
);
   typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] ir, ir_nxt;
   logic [31:0] pc_out_q, pc_out_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         ir       <= 32'h0;
         pc_out_q <= 32'h0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         ir       <= ir_nxt;
         pc_out_q <= pc_out_nxt;
      end
   end

   // Redirect overrides everything, including a completing read or a decode accept.
   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc;
      ir_nxt     = ir;
      pc_out_nxt = pc_out_q;
      if (bus.redirect) begin
         pc_nxt    = {bus.redirect_pc[31:2], 2'b00};
         state_nxt = bus.stall ? IDLE : REQ;
      end else begin
         case (state)
            IDLE: begin
               if (!bus.stall) state_nxt = REQ;
            end
            REQ: begin
               if (bus.mem_ready) begin
                  ir_nxt     = bus.mem_rdata;
                  pc_out_nxt = pc;
                  pc_nxt     = pc + 32'd4;
                  state_nxt  = HOLD;
               end
            end
            HOLD: begin
               if (bus.inst_ready) state_nxt = bus.stall ? IDLE : REQ;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign bus.mem_req    = (state == REQ);
   assign bus.mem_addr   = pc;
   assign bus.inst_valid = (state == HOLD);
   assign bus.pc_out     = pc_out_q;
   assign bus.inst       = ir;
   assign bus.opcode     = ir[31:26];
   assign bus.rs         = ir[25:21];
   assign bus.rt         = ir[20:16];
   assign bus.rd         = ir[15:11];
   assign bus.shamt      = ir[10:6];
   assign bus.funct      = ir[5:0];
   assign bus.imm_16     = ir[15:0];
   assign bus.j_target   = ir[25:0];
endmodule
